// File: rtl/alu_seq_defs.sv
// Shared definitions for the nibble-serial ALU sequencer: op codes,
// FSM state encoding and the slice width.
package alu_seq_defs;

    localparam int NIB_W = 4;

    // Op codes; bit 2 is the B-invert / carry-in control.
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/FourBitALU.sv
// Four-bit ALU slice: AND / OR / add with optional B inversion.
// op[1:0]: 00 AND, 01 OR, 10 sum, 11 pass 'less' into bit 0.
// op[2] inverts B; the caller supplies the matching carry-in.
module FourBitALU (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       less,
    input  logic [2:0] op,
    output logic [3:0] result,
    output logic       cout,
    output logic       zero,
    output logic       overflow
);

    logic [3:0] bb;
    logic [3:0] low;
    logic [4:0] full;

    // Ripple add with an explicit carry into bit 3 for the overflow flag.
    always_comb begin
        bb   = op[2] ? ~b : b;
        low  = {1'b0, a[2:0]} + {1'b0, bb[2:0]} + {3'b000, cin};
        full = {1'b0, a} + {1'b0, bb} + {4'b0000, cin};
        case (op[1:0])
            2'b00:   result = a & bb;
            2'b01:   result = a | bb;
            2'b10:   result = full[3:0];
            default: result = {3'b000, less};
        endcase
        cout     = full[4];
        overflow = low[3] ^ full[4];
        zero     = (result == 4'h0);
    end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial WIDTH-bit ALU: drives one FourBitALU slice per cycle,
// LSB nibble first, chaining carry through a register.
// Request/response handshakes: a transfer happens on a rising edge where
// valid and ready are both high; the producer holds valid and data stable
// until that edge, and the result stays frozen while out_valid && !out_ready.
// Optional build macro ALU_SEQ_PERF_CNT_EN adds perf_ops / perf_busy counters.
module alu_nibble_sequencer
    import alu_seq_defs::*;
#(
    parameter  int WIDTH = 32,
    localparam int NIB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_overflow,
    output logic             out_zero
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_busy
`endif
);

    localparam int IW = $clog2(NIB);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             zero_acc;

    logic [NIB_W-1:0] sl_a;
    logic [NIB_W-1:0] sl_b;
    logic [2:0]       sl_op;
    logic [NIB_W-1:0] sl_res;
    logic             sl_cout;
    logic             sl_zero;
    logic             sl_ovf;
    logic             is_logic;
    logic             is_slt;
    logic             last;
    logic             slt_bit;

    // Nibble select and slice op mapping; undefined codes run as add/sub.
    always_comb begin
        sl_a     = a_q[{idx, 2'b00} +: NIB_W];
        sl_b     = b_q[{idx, 2'b00} +: NIB_W];
        is_logic = (op_q == OP_AND) || (op_q == OP_OR);
        is_slt   = (op_q == OP_SLT);
        sl_op    = is_logic ? op_q : {op_q[2], 2'b10};
        last     = (idx == IW'(NIB - 1));
        slt_bit  = sl_res[3] ^ sl_ovf;
    end

    FourBitALU u_slice (
        .a        (sl_a),
        .b        (sl_b),
        .cin      (carry),
        .less     (1'b0),
        .op       (sl_op),
        .result   (sl_res),
        .cout     (sl_cout),
        .zero     (sl_zero),
        .overflow (sl_ovf)
    );

    // Control FSM with registered handshake outputs and result/flag capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_cout     <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b1;
            idx          <= '0;
            carry        <= 1'b0;
            zero_acc     <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_AND;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        op_q     <= in_op;
                        carry    <= in_op[2];
                        idx      <= '0;
                        zero_acc <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    out_result[{idx, 2'b00} +: NIB_W] <= sl_res;
                    carry    <= sl_cout;
                    zero_acc <= zero_acc & sl_zero;
                    if (last) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        if (is_slt) begin
                            out_result   <= {{(WIDTH-1){1'b0}}, slt_bit};
                            out_zero     <= ~slt_bit;
                            out_cout     <= sl_cout;
                            out_overflow <= sl_ovf;
                        end else if (is_logic) begin
                            out_zero     <= zero_acc & sl_zero;
                            out_cout     <= 1'b0;
                            out_overflow <= 1'b0;
                        end else begin
                            out_zero     <= zero_acc & sl_zero;
                            out_cout     <= sl_cout;
                            out_overflow <= sl_ovf;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_CNT_EN
    // Completed-op and busy-cycle counters, free-running with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops  <= '0;
            perf_busy <= '0;
        end else begin
            if (out_valid && out_ready) perf_ops <= perf_ops + 32'd1;
            if (state != S_IDLE)        perf_busy <= perf_busy + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: directed and random ops, scoreboard
// of expected results fed by the driver and drained by a monitor.
module tb_alu_nibble_sequencer;

    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;
    localparam int RW    = WIDTH + 3;       // {zero, ovf, cout, result}
    localparam int EW    = RW + 32;         // plus accept cycle stamp

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_cout;
    logic             out_overflow;
    logic             out_zero;
`ifdef ALU_SEQ_PERF_CNT_EN
    logic [31:0]      perf_ops;
    logic [31:0]      perf_busy;
`endif

    int               cyc = 0;
    int               checks = 0;
    int               failures = 0;
    logic [EW-1:0]    exp_q[$];
    bit               stall = 1'b0;

    alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_cout     (out_cout),
        .out_overflow (out_overflow),
        .out_zero     (out_zero)
`ifdef ALU_SEQ_PERF_CNT_EN
        ,
        .perf_ops     (perf_ops),
        .perf_busy    (perf_busy)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: random acceptance unless a stall is requested.
    always @(posedge clk) begin
        #1;
        out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // ---------------- reference model ----------------
    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [2:0] op);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010, 3'b011: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[WIDTH-1:0];
                c = s[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                s = {1'b0, a} - {1'b0, b} + {1'b1, {WIDTH{1'b0}}};
                r = a - b;
                c = (a >= b);
                v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
                if (op == 3'b111) r = ($signed(a) < $signed(b)) ? 1 : 0;
            end
        endcase
        return {(r == 0), v, c, r};
    endfunction

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit            seen = 1'b0;
    logic [RW-1:0] held;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (reset) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output result=%0h at cycle %0d", out_result, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("result",   64'(out_result),   64'(e[WIDTH-1:0]));
                    chk("cout",     64'(out_cout),     64'(e[WIDTH]));
                    chk("overflow", 64'(out_overflow), 64'(e[WIDTH+1]));
                    chk("zero",     64'(out_zero),     64'(e[WIDTH+2]));
                    chk("latency",  64'(cyc - int'(e[EW-1:RW])), 64'(NIB + 1));
                end
                seen = 1'b1;
                held = {out_zero, out_overflow, out_cout, out_result};
            end else begin
                chk("hold_stable", 64'({out_zero, out_overflow, out_cout, out_result}), 64'(held));
            end
            chk("in_ready_while_valid", 64'(in_ready), 64'(0));
            if (out_ready) seen = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] op, input bit expect_out);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout in_ready=%0b after %0d cycles", in_ready, n);
            return;
        end
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        if (expect_out) exp_q.push_back({cyc[31:0], model(a, b, op)});
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the captured operands must win.
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_op = 3'($urandom_range(0, 7));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d out_valid=%0b", exp_q.size(), out_valid);
        end
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'(0);
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h1; in_op = 3'b010;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),     64'(1));
        chk("rst_out_valid", 64'(out_valid),    64'(0));
        chk("rst_result",    64'(out_result),   64'(0));
        chk("rst_cout",      64'(out_cout),     64'(0));
        chk("rst_ovf",       64'(out_overflow), 64'(0));
        chk("rst_zero",      64'(out_zero),     64'(1));
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 64'(in_ready), 64'(1));

        // Directed cases.
        do_op(32'h0000_000F, 32'h0000_0001, 3'b010, 1);
        do_op(32'h8000_0000, 32'h0000_0001, 3'b110, 1);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 1);
        do_op(32'hFFFF_FFFE, 32'h0000_0003, 3'b111, 1);
        do_op(32'h0000_0003, 32'hFFFF_FFFE, 3'b111, 1);
        do_op(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, 1);
        do_op(32'h0000_0000, 32'h0000_0000, 3'b001, 1);
        do_op(32'h0000_0005, 32'h0000_0007, 3'b011, 1);
        do_op(32'h0000_0005, 32'h0000_0007, 3'b100, 1);
        do_op(32'h8000_0000, 32'h0000_0001, 3'b111, 1);
        drain();

        // Backpressure plus a stray request while busy.
        stall = 1'b1;
        do_op(32'h1234_5678, 32'h1111_1111, 3'b010, 1);
        @(negedge clk);
        chk("in_ready_run", 64'(in_ready), 64'(0));
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_op = 3'b001;
        @(negedge clk);
        in_valid = 1'b0;
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("stall_valid_seen", 64'(out_valid), 64'(1));
        end
        repeat (5) @(negedge clk);
        stall = 1'b0;
        drain();

        // Reset in the middle of an ADD; the partial result is dropped.
        do_op(32'h0FFF_FFFF, 32'h0000_0001, 3'b010, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_in_ready",  64'(in_ready),   64'(1));
        chk("midrst_out_valid", 64'(out_valid),  64'(0));
        chk("midrst_zero",      64'(out_zero),   64'(1));
        chk("midrst_result",    64'(out_result), 64'(0));
        do_op(32'h0000_0100, 32'h0000_00FF, 3'b010, 1);
        drain();

        // Random ops with random operand classes and random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            do_op(pick(), pick(), 3'($urandom_range(0, 7)), 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
